// File: rtl/gelato_ifetch.sv
// Instruction-fetch stage: buffers scheduler fetch tuples in an in-order queue,
// issues one icache read at a time and hands each instruction to the decoder.
module gelato_ifetch #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WARP_NUM_W  = 5,
  parameter int unsigned SPLIT_NUM_W = 3,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fs_valid,
  input  logic [ADDR_W-1:0]      fs_pc,
  input  logic [WARP_NUM_W-1:0]  fs_warp_num,
  input  logic [SPLIT_NUM_W-1:0] fs_split_table_num,
  output logic                   fs_stall,
  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [ADDR_W-1:0]      icache_req_addr,
  input  logic                   icache_rsp_valid,
  input  logic [INST_W-1:0]      icache_rsp_data,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INST_W-1:0]      dec_inst,
  output logic [ADDR_W-1:0]      dec_pc,
  output logic [WARP_NUM_W-1:0]  dec_warp_num,
  output logic [SPLIT_NUM_W-1:0] dec_split_table_num,
  output logic                   overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [ADDR_W-1:0]      pc_mem    [DEPTH];
  logic [WARP_NUM_W-1:0]  warp_mem  [DEPTH];
  logic [SPLIT_NUM_W-1:0] split_mem [DEPTH];

  logic push, pop, drop;
  logic req_valid, out_valid;

  // A full queue still accepts when the head leaves in the same cycle.
  assign pop  = (state_q == S_OUT) && dec_ready;
  assign push = fs_valid && ((count_q != CNT_FULL) || pop);
  assign drop = fs_valid && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    req_valid = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        req_valid = (count_q != '0);
        if (req_valid && icache_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (icache_rsp_valid) begin
          inst_d  = icache_rsp_data;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (dec_ready) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      inst_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: it is only visible through gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fs_pc;
      warp_mem[wr_ptr_q]  <= fs_warp_num;
      split_mem[wr_ptr_q] <= fs_split_table_num;
    end
  end

  assign fs_stall            = (count_q >= CNT_STALL);
  assign overflow            = overflow_q;
  assign icache_req_valid    = req_valid;
  assign icache_req_addr     = req_valid ? pc_mem[rd_ptr_q] : '0;
  assign dec_valid           = out_valid;
  assign dec_inst            = out_valid ? inst_q : '0;
  assign dec_pc              = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign dec_warp_num        = out_valid ? warp_mem[rd_ptr_q] : '0;
  assign dec_split_table_num = out_valid ? split_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_gelato_ifetch.sv
// Scoreboard bench for gelato_ifetch: expected fetches queued as the scheduler
// issues them, compared in order as the decoder accepts instructions.
module tb_gelato_ifetch;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  warp;
    logic [2:0]  split;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs_valid = 1'b0;
  logic [31:0] fs_pc = '0;
  logic [4:0]  fs_warp_num = '0;
  logic [2:0]  fs_split_table_num = '0;
  logic        fs_stall;
  logic        icache_req_valid;
  logic        icache_req_ready = 1'b0;
  logic [31:0] icache_req_addr;
  logic        icache_rsp_valid = 1'b0;
  logic [31:0] icache_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [4:0]  dec_warp_num;
  logic [2:0]  dec_split_table_num;
  logic        overflow;

  gelato_ifetch #(
    .ADDR_W(32), .WARP_NUM_W(5), .SPLIT_NUM_W(3), .INST_W(32), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_warp_num(fs_warp_num),
    .fs_split_table_num(fs_split_table_num), .fs_stall(fs_stall),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_data(icache_rsp_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_warp_num(dec_warp_num),
    .dec_split_table_num(dec_split_table_num), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Knobs written only by the main sequence.
  bit          auto_en = 1'b0;
  int          dec_mode = 1;
  int          rdy_pct = 100, rsp_pct = 100, junk_pct = 0;
  bit          man_req_ready = 1'b0;
  bit          man_rsp_valid = 1'b0;
  logic [31:0] man_rsp_data = '0;

  // Reference model state, owned by the scoreboard process.
  fetch_t      expq[$];
  logic [31:0] respq[$];
  bit          outstanding = 1'b0;
  bit          exp_ovf = 1'b0;
  int          n_deliv = 0;
  logic [31:0] last_pc = '0;
  bit          hold = 1'b0;
  logic [31:0] hold_inst, hold_pc;
  logic [4:0]  hold_warp;
  logic [2:0]  hold_split;

  int chk_m = 0, pass_m = 0;
  int chk_d = 0, pass_d = 0;
  int n_checks = 0, n_passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp,
                       inout int nc, inout int np);
    nc++;
    n_checks++;
    if (act === exp) begin
      np++;
      n_passed++;
    end else begin
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Icache/decoder responder plus scoreboard monitor in one process.
  always begin : scoreboard
    fetch_t      e;
    logic [31:0] d;
    bit          pop, full;
    @(posedge clk);
    #2;
    if (auto_en) begin
      icache_req_ready = ($urandom_range(0, 99) < rdy_pct);
      if (outstanding) begin
        if ($urandom_range(0, 99) < rsp_pct) begin
          d = $urandom;
          icache_rsp_valid = 1'b1;
          icache_rsp_data  = d;
          respq.push_back(d);
          outstanding = 1'b0;
        end else begin
          icache_rsp_valid = 1'b0;
          icache_rsp_data  = $urandom;
        end
      end else begin
        icache_rsp_valid = ($urandom_range(0, 99) < junk_pct);
        icache_rsp_data  = $urandom;
      end
    end else begin
      icache_req_ready = man_req_ready;
      icache_rsp_valid = man_rsp_valid;
      icache_rsp_data  = man_rsp_data;
      if (man_rsp_valid && outstanding) begin
        respq.push_back(man_rsp_data);
        outstanding = 1'b0;
      end
    end
    case (dec_mode)
      0:       dec_ready = 1'b0;
      1:       dec_ready = 1'b1;
      default: dec_ready = 1'($urandom_range(0, 1));
    endcase

    @(negedge clk);
    if (!rst_n) begin
      expq.delete();
      respq.delete();
      outstanding = 1'b0;
      exp_ovf     = 1'b0;
      hold        = 1'b0;
    end else begin
      pop  = dec_valid && dec_ready;
      full = (expq.size() == DEPTH);
      check("fs_stall", fs_stall, (expq.size() >= DEPTH - 1), chk_m, pass_m);
      check("overflow", overflow, exp_ovf, chk_m, pass_m);
      if (!icache_req_valid) check("req_addr_idle", icache_req_addr, 0, chk_m, pass_m);
      if (icache_req_valid && icache_req_ready) begin
        check("req_has_entry", (expq.size() != 0), 1, chk_m, pass_m);
        if (expq.size() != 0) check("req_addr", icache_req_addr, expq[0].pc, chk_m, pass_m);
        check("req_one_outstanding", outstanding, 0, chk_m, pass_m);
        outstanding = 1'b1;
      end
      if (hold) begin
        check("hold_valid", dec_valid, 1, chk_m, pass_m);
        check("hold_inst", dec_inst, hold_inst, chk_m, pass_m);
        check("hold_pc", dec_pc, hold_pc, chk_m, pass_m);
        check("hold_tags", {dec_warp_num, dec_split_table_num}, {hold_warp, hold_split}, chk_m, pass_m);
      end
      hold       = dec_valid && !dec_ready;
      hold_inst  = dec_inst;
      hold_pc    = dec_pc;
      hold_warp  = dec_warp_num;
      hold_split = dec_split_table_num;
      if (pop) begin
        check("dec_expected", (expq.size() != 0 && respq.size() != 0), 1, chk_m, pass_m);
        if (expq.size() != 0 && respq.size() != 0) begin
          e = expq.pop_front();
          d = respq.pop_front();
          check("dec_inst", dec_inst, d, chk_m, pass_m);
          check("dec_pc", dec_pc, e.pc, chk_m, pass_m);
          check("dec_warp", dec_warp_num, e.warp, chk_m, pass_m);
          check("dec_split", dec_split_table_num, e.split, chk_m, pass_m);
        end
        n_deliv++;
        last_pc = dec_pc;
      end
      if (fs_valid) begin
        if (!full || pop) begin
          e.pc = fs_pc; e.warp = fs_warp_num; e.split = fs_split_table_num;
          expq.push_back(e);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {fs_stall, icache_req_valid, dec_valid, overflow}, 0, chk_d, pass_d);
    check({tag, "_addr"}, {icache_req_addr, dec_pc}, 0, chk_d, pass_d);
    check({tag, "_dec"}, {dec_inst, dec_warp_num, dec_split_table_num}, 0, chk_d, pass_d);
  endtask

  task automatic drive_fs(input logic [31:0] pc, input logic [4:0] w, input logic [2:0] s);
    @(posedge clk); #1;
    fs_valid = 1'b1; fs_pc = pc; fs_warp_num = w; fs_split_table_num = s;
  endtask

  task automatic idle_fs();
    @(posedge clk); #1;
    fs_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output bit saw_stall);
    bit ok = 1'b0;
    saw_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (fs_stall) saw_stall = 1'b1;
      if (expq.size() == 0 && !dec_valid && !outstanding && !icache_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_drain_in_time"}, ok, 1, chk_d, pass_d);
  endtask

  task automatic wait_dec_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dec_valid) begin ok = 1'b1; break; end
    end
    check({tag, "_dec_valid_in_time"}, ok, 1, chk_d, pass_d);
  endtask

  // Directed minimum-latency fetch, icache driven by hand.
  task automatic single_fetch(input logic [31:0] pc, input logic [4:0] w, input logic [2:0] s,
                              input logic [31:0] data);
    @(posedge clk); #1;
    auto_en = 1'b0; dec_mode = 1; man_req_ready = 1'b1; man_rsp_valid = 1'b0;
    fs_valid = 1'b1; fs_pc = pc; fs_warp_num = w; fs_split_table_num = s;
    @(negedge clk);
    check("lat_c0_req", icache_req_valid, 0, chk_d, pass_d);
    idle_fs();
    @(negedge clk);
    check("lat_c1_req", icache_req_valid, 1, chk_d, pass_d);
    check("lat_c1_addr", icache_req_addr, pc, chk_d, pass_d);
    @(posedge clk); #1;
    man_rsp_valid = 1'b1; man_rsp_data = data;
    @(negedge clk);
    check("lat_c2_dec", dec_valid, 0, chk_d, pass_d);
    @(posedge clk); #1;
    man_rsp_valid = 1'b0;
    @(negedge clk);
    check("lat_c3_dec", dec_valid, 1, chk_d, pass_d);
    check("lat_c3_inst", dec_inst, data, chk_d, pass_d);
    check("lat_c3_tags", {dec_pc, dec_warp_num, dec_split_table_num}, {pc, w, s}, chk_d, pass_d);
    @(negedge clk);
    check("lat_idle", {dec_valid, icache_req_valid}, 0, chk_d, pass_d);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit          stall_seen;
    int          n0;
    logic [31:0] h_inst, h_pc;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Single fetch with minimum latency
    single_fetch(32'h8000_0000, 5'd3, 3'd1, 32'h0050_0093);

    // Ordering and advisory stall
    @(posedge clk); #1;
    auto_en = 1'b1; rdy_pct = 100; rsp_pct = 100; junk_pct = 0; dec_mode = 1;
    n0 = n_deliv;
    drive_fs(32'h100, 5'd1, 3'd2);
    drive_fs(32'h104, 5'd2, 3'd3);
    drive_fs(32'h108, 5'd4, 3'd5);
    idle_fs();
    wait_idle("order", stall_seen);
    check("order_stall_seen", stall_seen, 1, chk_d, pass_d);
    check("order_count", n_deliv - n0, 3, chk_d, pass_d);
    check("order_no_overflow", overflow, 0, chk_d, pass_d);

    // Decoder backpressure with stray icache responses
    @(posedge clk); #1;
    junk_pct = 60; dec_mode = 0;
    n0 = n_deliv;
    drive_fs(32'h0000_1234, 5'd7, 3'd6);
    idle_fs();
    wait_dec_valid("bp");
    h_inst = dec_inst; h_pc = dec_pc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_stable", {dec_valid, dec_inst, dec_pc}, {1'b1, h_inst, h_pc}, chk_d, pass_d);
    end
    @(posedge clk); #1;
    dec_mode = 1;
    wait_idle("bp", stall_seen);
    check("bp_one_transfer", n_deliv - n0, 1, chk_d, pass_d);

    // Full queue with simultaneous push and pop
    @(posedge clk); #1;
    junk_pct = 0; dec_mode = 0;
    drive_fs(32'h1F0, 5'd10, 3'd0);
    drive_fs(32'h1F4, 5'd11, 3'd1);
    drive_fs(32'h1F8, 5'd12, 3'd2);
    drive_fs(32'h1FC, 5'd13, 3'd3);
    idle_fs();
    wait_dec_valid("full");
    repeat (2) @(negedge clk);
    check("full_stall", fs_stall, 1, chk_d, pass_d);
    @(posedge clk); #1;
    fs_valid = 1'b1; fs_pc = 32'h200; fs_warp_num = 5'd20; fs_split_table_num = 3'd4;
    dec_mode = 1;
    @(posedge clk); #1;
    fs_valid = 1'b0; dec_mode = 0;
    @(negedge clk);
    check("full_no_overflow", overflow, 0, chk_d, pass_d);
    check("full_still_stalled", fs_stall, 1, chk_d, pass_d);
    @(posedge clk); #1;
    dec_mode = 1;
    wait_idle("full", stall_seen);
    check("full_last_pc", last_pc, 32'h200, chk_d, pass_d);

    // Randomized traffic
    @(posedge clk); #1;
    rdy_pct = 70; rsp_pct = 60; junk_pct = 30; dec_mode = 2;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      fs_valid = fs_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      fs_pc = $urandom;
      fs_warp_num = 5'($urandom);
      fs_split_table_num = 3'($urandom);
    end
    @(posedge clk); #1;
    fs_valid = 1'b0; dec_mode = 1;
    wait_idle("rand", stall_seen);

    // Overflow: five back-to-back fetches with the decoder stalled
    @(posedge clk); #1;
    rdy_pct = 100; rsp_pct = 100; junk_pct = 0; dec_mode = 0;
    for (int i = 0; i < 5; i++) drive_fs(32'h400 + 32'(i * 4), 5'(i), 3'(i));
    idle_fs();
    repeat (2) @(negedge clk);
    check("ovf_set", overflow, 1, chk_d, pass_d);
    n0 = n_deliv;
    @(posedge clk); #1;
    dec_mode = 1;
    wait_idle("ovf", stall_seen);
    check("ovf_delivered", n_deliv - n0, 4, chk_d, pass_d);
    check("ovf_sticky", overflow, 1, chk_d, pass_d);

    // Reset while waiting on the icache
    @(posedge clk); #1;
    auto_en = 1'b0; man_req_ready = 1'b1; man_rsp_valid = 1'b0; dec_mode = 1;
    fs_valid = 1'b1; fs_pc = 32'h2F0; fs_warp_num = 5'd9; fs_split_table_num = 3'd7;
    idle_fs();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    man_rsp_valid = 1'b1; man_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_rsp_ignored", dec_valid, 0, chk_d, pass_d);
    @(posedge clk); #1;
    man_rsp_valid = 1'b0;
    @(negedge clk);
    check("rst_idle", {dec_valid, icache_req_valid, overflow}, 0, chk_d, pass_d);
    single_fetch(32'h300, 5'd5, 3'd2, 32'h00A0_0113);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
